// File: rtl/muxpipe_if.sv
// muxpipe_if: handshake/data bundle between an upstream producer, the muxpipe
// channel selector and a downstream consumer.
interface muxpipe_if #(
   parameter int unsigned N  = 8,
   parameter int unsigned DW = 8
);
   logic [N-1:0]    sel;
   logic [N*DW-1:0] in;
   logic            in_valid;
   logic            in_ready;
   logic [DW-1:0]   out;
   logic            out_err;
   logic            out_valid;
   logic            out_ready;

   // Producer/consumer side (drives beats in, accepts beats out)
   modport master (
      output sel, in, in_valid, out_ready,
      input  in_ready, out, out_err, out_valid
   );

   // muxpipe side
   modport slave (
      input  sel, in, in_valid, out_ready,
      output in_ready, out, out_err, out_valid
   );
endinterface

// File: rtl/muxpipe.sv
// muxpipe: one-hot N:1 channel mux feeding a 2-entry skid buffer.
// Non-one-hot selects produce a zero beat flagged with out_err.
// Optional feature macro: MUXPIPE_ERRCNT_EN adds the saturating err_count port.
module muxpipe #(
   parameter int unsigned N  = 8,
   parameter int unsigned DW = 8,
   parameter int unsigned CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   muxpipe_if.slave      bus
`ifdef MUXPIPE_ERRCNT_EN
   ,
   output logic [CW-1:0] err_count
`endif
);

   // Elaboration-time parameter sanity
   if (N < 2)  begin : g_bad_n  $error("muxpipe: N must be >= 2");  end
   if (CW < 1) begin : g_bad_cw $error("muxpipe: CW must be >= 1"); end

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [DW-1:0] head_data_q, head_data_d;
   logic [DW-1:0] tail_data_q, tail_data_d;
   logic          head_err_q, head_err_d;
   logic          tail_err_q, tail_err_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;

   logic          push;
   logic          pop;
   logic          onehot;
   logic [DW-1:0] mux_data;
   logic          mux_err;

   // Handshakes; in_ready comes from a flop so out_ready never reaches it
   assign push = bus.in_valid & in_ready_q;
   assign pop  = out_valid_q & bus.out_ready;

   // Select decode: OR-mux of selected channels, forced to zero unless one-hot
   always_comb begin
      mux_data = '0;
      onehot   = (bus.sel != '0) && ((bus.sel & (bus.sel - N'(1))) == '0);
      for (int i = 0; i < int'(N); i++) begin
         if (bus.sel[i]) begin
            mux_data = mux_data | bus.in[DW*i +: DW];
         end
      end
      if (!onehot) begin
         mux_data = '0;
      end
      mux_err = ~onehot;
   end

   // Skid buffer next state: head is the presented beat, tail the overflow slot
   always_comb begin
      state_d     = state_q;
      head_data_d = head_data_q;
      head_err_d  = head_err_q;
      tail_data_d = tail_data_q;
      tail_err_d  = tail_err_q;
      case (state_q)
         EMPTY: begin
            if (push) begin
               head_data_d = mux_data;
               head_err_d  = mux_err;
               state_d     = ONE;
            end
         end
         ONE: begin
            if (push && pop) begin
               head_data_d = mux_data;
               head_err_d  = mux_err;
            end else if (push) begin
               tail_data_d = mux_data;
               tail_err_d  = mux_err;
               state_d     = TWO;
            end else if (pop) begin
               state_d     = EMPTY;
            end
         end
         TWO: begin
            // in_ready is low here, so no push can occur
            if (pop) begin
               head_data_d = tail_data_q;
               head_err_d  = tail_err_q;
               state_d     = ONE;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
      in_ready_d  = (state_d != TWO);
      out_valid_d = (state_d != EMPTY);
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY;
         head_data_q <= '0;
         head_err_q  <= 1'b0;
         tail_data_q <= '0;
         tail_err_q  <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         head_data_q <= head_data_d;
         head_err_q  <= head_err_d;
         tail_data_q <= tail_data_d;
         tail_err_q  <= tail_err_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out       = head_data_q;
   assign bus.out_err   = head_err_q;

`ifdef MUXPIPE_ERRCNT_EN
   logic [CW-1:0] err_cnt_q, err_cnt_d;

   // Saturating count of accepted error beats
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (push && mux_err && (err_cnt_q != {CW{1'b1}})) begin
         err_cnt_d = err_cnt_q + CW'(1);
      end
   end

   // Error counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_muxpipe.sv
// tb_muxpipe: randomized and directed checks of muxpipe against a queue model.
// Build with MUXPIPE_ERRCNT_EN defined to also cover err_count.
module tb_muxpipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errs   = 0;
   int   checks = 0;

   logic [8:0] q[$];   // expected buffered beats, {err, data}, head first
   int         errc = 0;

   always #5 clk = ~clk;

   muxpipe_if #(.N(8), .DW(8)) bus ();

`ifdef MUXPIPE_ERRCNT_EN
   logic [7:0] err_count;
   muxpipe #(.N(8), .DW(8), .CW(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave), .err_count(err_count));

   muxpipe_if #(.N(8), .DW(8)) bus2 ();
   logic [1:0] err_count2;
   muxpipe #(.N(8), .DW(8), .CW(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave), .err_count(err_count2));
`else
   muxpipe #(.N(8), .DW(8), .CW(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
`endif

   // Expected beat for a select/data pair
   function automatic logic [8:0] ref_beat(input logic [7:0] s, input logic [63:0] d);
      logic [8:0] r;
      r = 9'h100;
      if ($countones(s) == 1) begin
         for (int i = 0; i < 8; i++) begin
            if (s[i]) r = {1'b0, d[8*i +: 8]};
         end
      end
      return r;
   endfunction

   // Advance one clock, updating the queue model from pre-edge handshakes
   task automatic step();
      bit         acc, pp;
      logic [8:0] b;
      acc = !rst && bus.in_valid && (q.size() < 2);
      pp  = !rst && bus.out_ready && (q.size() > 0);
      b   = ref_beat(bus.sel, bus.in);
      @(posedge clk);
      if (rst) begin
         q.delete();
         errc = 0;
      end else begin
         if (pp) void'(q.pop_front());
         if (acc) begin
            q.push_back(b);
            if (b[8] && errc < 255) errc++;
         end
      end
      #1;
   endtask

   function automatic logic [7:0] rand_onehot();
      logic [7:0] s;
      s = 8'h01 << ($urandom % 8);
      return s;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b1;
      bus.sel = rand_onehot();
      bus.in = {$urandom, $urandom};
      bus.out_ready = 1'b0;
      step();
      step();
      checks++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %b exp 1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b exp 0", bus.out_valid); end
      checks++; if (bus.out !== 8'h00) begin errs++; $display("FAIL reset_out: got %h exp 00", bus.out); end
      checks++; if (bus.out_err !== 1'b0) begin errs++; $display("FAIL reset_out_err: got %b exp 0", bus.out_err); end
`ifdef MUXPIPE_ERRCNT_EN
      checks++; if (err_count !== 8'd0) begin errs++; $display("FAIL reset_err_count: got %0d exp 0", err_count); end
`endif
      rst = 1'b0;
      bus.in_valid = 1'b0;
      step();
      checks++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL reset_no_accept: got %b exp 0", bus.out_valid); end
   endtask

   task automatic test_directed();
      logic [63:0] d;
      d = {$urandom, $urandom};
      d[23:16] = 8'hA5;
      bus.sel = 8'h04;
      bus.in = d;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      checks++; if (bus.out !== 8'hA5) begin errs++; $display("FAIL dir_out: got %h exp a5", bus.out); end
      checks++; if (bus.out_valid !== 1'b1) begin errs++; $display("FAIL dir_valid: got %b exp 1", bus.out_valid); end
      checks++; if (bus.out_err !== 1'b0) begin errs++; $display("FAIL dir_err: got %b exp 0", bus.out_err); end
      step();
      checks++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL dir_drain: got %b exp 0", bus.out_valid); end
   endtask

   task automatic test_errors();
      logic [7:0] sels [2];
      sels[0] = 8'h00;
      sels[1] = 8'h11;
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
         bus.sel = sels[k];
         bus.in = {$urandom, $urandom};
         step();
         checks++; if (bus.out !== 8'h00) begin errs++; $display("FAIL err_out[%0d]: got %h exp 00", k, bus.out); end
         checks++; if (bus.out_err !== 1'b1) begin errs++; $display("FAIL err_flag[%0d]: got %b exp 1", k, bus.out_err); end
         checks++; if (bus.out_valid !== 1'b1) begin errs++; $display("FAIL err_valid[%0d]: got %b exp 1", k, bus.out_valid); end
      end
      bus.in_valid = 1'b0;
      step();
`ifdef MUXPIPE_ERRCNT_EN
      checks++; if (err_count !== 8'(errc)) begin errs++; $display("FAIL err_count: got %0d exp %0d", err_count, errc); end
`endif
   endtask

   task automatic test_backpressure();
      logic [63:0] d [3];
      logic [7:0]  s [3];
      logic [7:0]  exp_b [3];
      logic        exp_rdy [3];
      logic [7:0]  got[$];
      bit          b3_taken;
      exp_rdy[0] = 1'b1; exp_rdy[1] = 1'b0; exp_rdy[2] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         s[k] = 8'h01 << k;
         d[k] = {$urandom, $urandom};
         exp_b[k] = d[k][8*k +: 8];
      end
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.sel = s[k];
         bus.in = d[k];
         step();
         checks++; if (bus.in_ready !== exp_rdy[k]) begin errs++; $display("FAIL bp_in_ready[%0d]: got %b exp %b", k, bus.in_ready, exp_rdy[k]); end
         checks++; if (bus.out !== exp_b[0]) begin errs++; $display("FAIL bp_hold[%0d]: got %h exp %h", k, bus.out, exp_b[0]); end
      end
      bus.out_ready = 1'b1;
      b3_taken = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (bus.out_valid) got.push_back(bus.out);
         if (bus.in_valid && bus.in_ready) b3_taken = 1'b1;
         step();
         if (b3_taken) bus.in_valid = 1'b0;
      end
      checks++; if (got.size() != 3) begin errs++; $display("FAIL bp_count: got %0d exp 3", got.size()); end
      for (int k = 0; k < 3; k++) begin
         if (k < got.size()) begin
            checks++; if (got[k] !== exp_b[k]) begin errs++; $display("FAIL bp_order[%0d]: got %h exp %h", k, got[k], exp_b[k]); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         bus.sel = 8'h01 << (k % 8);
         bus.in = {$urandom, $urandom};
         exp = bus.in[8*(k%8) +: 8];
         step();
         checks++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready[%0d]: got %b exp 1", k, bus.in_ready); end
         checks++; if (bus.out_valid !== 1'b1 || bus.out !== exp) begin errs++; $display("FAIL b2b_out[%0d]: got v=%b %h exp v=1 %h", k, bus.out_valid, bus.out, exp); end
      end
      bus.in_valid = 1'b0;
      step();
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         bus.in_valid = ($urandom % 4) != 0;
         bus.out_ready = ($urandom % 3) != 0;
         bus.sel = (($urandom % 6) == 0) ? 8'($urandom) : rand_onehot();
         bus.in = {$urandom, $urandom};
         step();
         checks++; if (bus.in_ready !== (q.size() < 2)) begin errs++; $display("FAIL rnd_ready[%0d]: got %b exp %b", k, bus.in_ready, q.size() < 2); end
         checks++; if (bus.out_valid !== (q.size() > 0)) begin errs++; $display("FAIL rnd_valid[%0d]: got %b exp %b", k, bus.out_valid, q.size() > 0); end
         if (q.size() > 0) begin
            checks++; if ({bus.out_err, bus.out} !== q[0]) begin errs++; $display("FAIL rnd_beat[%0d]: got %h exp %h", k, {bus.out_err, bus.out}, q[0]); end
         end
`ifdef MUXPIPE_ERRCNT_EN
         checks++; if (err_count !== 8'(errc)) begin errs++; $display("FAIL rnd_err_count[%0d]: got %0d exp %0d", k, err_count, errc); end
`endif
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      step();
      step();
   endtask

   task automatic test_reset_mid();
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      bus.sel = 8'h00;
      for (int k = 0; k < 3; k++) step();
      checks++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL mid_full: got %b exp 0", bus.in_ready); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL mid_valid: got %b exp 0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL mid_ready: got %b exp 1", bus.in_ready); end
`ifdef MUXPIPE_ERRCNT_EN
      checks++; if (err_count !== 8'd0) begin errs++; $display("FAIL mid_err_count: got %0d exp 0", err_count); end
`endif
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         checks++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL mid_stale[%0d]: got %b exp 0", k, bus.out_valid); end
      end
   endtask

`ifdef MUXPIPE_ERRCNT_EN
   task automatic test_saturate();
      bus2.sel = 8'h00;
      bus2.in = {$urandom, $urandom};
      bus2.out_ready = 1'b1;
      bus2.in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin
            checks++; if (err_count2 !== 2'd2) begin errs++; $display("FAIL sat_mid: got %0d exp 2", err_count2); end
         end
      end
      bus2.in_valid = 1'b0;
      checks++; if (err_count2 !== 2'd3) begin errs++; $display("FAIL sat_final: got %0d exp 3", err_count2); end
   endtask
`endif

   initial begin
      bus.sel = '0;
      bus.in = '0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
`ifdef MUXPIPE_ERRCNT_EN
      bus2.sel = '0;
      bus2.in = '0;
      bus2.in_valid = 1'b0;
      bus2.out_ready = 1'b0;
`endif
      test_reset();
      test_directed();
      test_errors();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_mid();
`ifdef MUXPIPE_ERRCNT_EN
      test_saturate();
`endif
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
